// File: rtl/tenbaset_pkg.sv
// rtl/tenbaset_pkg.sv - shared types for the 10BASE-T receive frame controller
package tenbaset_pkg;

  localparam int NUM_BANKS  = 2;
  localparam int RAM_ADDR_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DISCARD,
    ST_COMMIT
  } rx_state_t;

  typedef struct packed {
    logic                  bank;
    logic [RAM_ADDR_W-1:0] len;
  } rdy_entry_t;

endpackage

// File: rtl/tenbaset_rx_frame_ctrl_if.sv
// rtl/tenbaset_rx_frame_ctrl_if.sv - completed-frame valid/ack handshake to the downstream consumer
interface tenbaset_rx_frame_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              frm_valid;
  logic              frm_bank;
  logic [ADDR_W-1:0] frm_len;
  logic              frm_ack;

  modport master (output frm_valid, frm_bank, frm_len, input frm_ack);
  modport slave  (input frm_valid, frm_bank, frm_len, output frm_ack);
endinterface

// File: rtl/tenbaset_bank_tracker.sv
// rtl/tenbaset_bank_tracker.sv - per-bank full flags and 2-entry ready queue of committed frames
module tenbaset_bank_tracker
  import tenbaset_pkg::*;
(
  input  logic                     clk48,
  input  logic                     rst,
  input  logic                     push,
  input  rdy_entry_t               push_ent,
  output logic [NUM_BANKS-1:0]     bank_full,
  tenbaset_rx_frame_ctrl_if.master frm
);

  rdy_entry_t [1:0] q;
  logic [1:0]       cnt;
  logic             pop;

  assign pop           = frm.frm_ack & (cnt != 2'd0);
  assign frm.frm_valid = (cnt != 2'd0);
  assign frm.frm_bank  = q[0].bank;
  assign frm.frm_len   = q[0].len;

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      q         <= '0;
      cnt       <= 2'd0;
      bank_full <= '0;
    end else begin
      if (pop)  bank_full[q[0].bank]     <= 1'b0;
      if (push) bank_full[push_ent.bank] <= 1'b1;
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            q[0] <= push_ent;
            cnt  <= 2'd1;
          end else if (cnt == 2'd1) begin
            q[1] <= push_ent;
            cnt  <= 2'd2;
          end
        end
        2'b01: begin
          q[0] <= q[1];
          cnt  <= cnt - 2'd1;
        end
        // Simultaneous push and pop: occupancy unchanged, new entry slides in behind
        2'b11: begin
          if (cnt == 2'd1) begin
            q[0] <= push_ent;
          end else begin
            q[0] <= q[1];
            q[1] <= push_ent;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tenbaset_rx_frame_ctrl.sv
// rtl/tenbaset_rx_frame_ctrl.sv - 10BASE-T receive frame sequencer into ping-pong RAM banks; RX_MAC_FILTER_EN enables destination filtering
module tenbaset_rx_frame_ctrl
  import tenbaset_pkg::*;
#(
  parameter int ADDR_W  = RAM_ADDR_W,
  parameter int MIN_LEN = 8,
  parameter int MAX_LEN = 511
`ifdef RX_MAC_FILTER_EN
  ,
  parameter logic [47:0] MAC_ADDR = 48'h0010A4_7BEA80
`endif
) (
  input  logic                     clk48,
  input  logic                     rst,
  input  logic                     rx_byte_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_eof,
  output logic                     ram_we,
  output logic [ADDR_W:0]          ram_addr,
  output logic [7:0]               ram_wdata,
  output logic [7:0]               drop_cnt,
  tenbaset_rx_frame_ctrl_if.master frm
);

  localparam logic [ADDR_W-1:0] MIN_L = ADDR_W'(MIN_LEN);
  localparam logic [ADDR_W-1:0] MAX_L = ADDR_W'(MAX_LEN);

  rx_state_t             st, st_nxt;
  logic [ADDR_W-1:0]     len, len_nxt, wr_off;
  logic                  wr_bank, rx_eof_q, eof_evt;
  logic                  wr_en, drop_inc, push, mac_miss;
  logic [NUM_BANKS-1:0]  bank_full;
  rdy_entry_t            push_ent;

  assign eof_evt  = rx_eof & ~rx_eof_q;
  assign push     = (st == ST_COMMIT);
  assign push_ent = '{bank: wr_bank, len: len};

`ifdef RX_MAC_FILTER_EN
  logic              mac_ok, bc_ok, mac_hit, bc_hit, in_hdr;
  logic [ADDR_W-1:0] idx;
  logic [47:0]       mac_sh;

  // A header byte passes if it continues either the station-address or the broadcast prefix
  assign idx      = (st == ST_IDLE) ? '0 : len;
  assign in_hdr   = (idx < ADDR_W'(6));
  assign mac_sh   = MAC_ADDR << (8 * idx);
  assign mac_hit  = ((st == ST_IDLE) | mac_ok) & (rx_byte == mac_sh[47:40]);
  assign bc_hit   = ((st == ST_IDLE) | bc_ok) & (rx_byte == 8'hFF);
  assign mac_miss = in_hdr & ~mac_hit & ~bc_hit;

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      mac_ok <= 1'b0;
      bc_ok  <= 1'b0;
    end else if (wr_en & in_hdr) begin
      mac_ok <= mac_hit;
      bc_ok  <= bc_hit;
    end
  end
`else
  assign mac_miss = 1'b0;
`endif

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) st <= ST_IDLE;
    else     st <= st_nxt;
  end

  // The byte is applied first; eof_evt then acts on the post-byte state and length
  always_comb begin
    st_nxt   = st;
    len_nxt  = len;
    wr_en    = 1'b0;
    wr_off   = len;
    drop_inc = 1'b0;
    case (st)
      ST_IDLE: begin
        if (rx_byte_valid) begin
          if (bank_full[wr_bank] | mac_miss) begin
            st_nxt   = ST_DISCARD;
            drop_inc = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_off  = '0;
            len_nxt = ADDR_W'(1);
            st_nxt  = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (rx_byte_valid) begin
          if ((len == MAX_L) | mac_miss) begin
            st_nxt   = ST_DISCARD;
            drop_inc = 1'b1;
          end else begin
            wr_en   = 1'b1;
            len_nxt = len + 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (eof_evt) begin
      if (st_nxt == ST_RECV) begin
        if (len_nxt >= MIN_L) begin
          st_nxt = ST_COMMIT;
        end else begin
          st_nxt   = ST_IDLE;
          drop_inc = 1'b1;
        end
      end else if (st_nxt == ST_DISCARD) begin
        st_nxt = ST_IDLE;
      end
    end
    if (st == ST_COMMIT) st_nxt = ST_IDLE;
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      len       <= '0;
      wr_bank   <= 1'b0;
      rx_eof_q  <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      drop_cnt  <= '0;
    end else begin
      len      <= len_nxt;
      rx_eof_q <= rx_eof;
      ram_we   <= wr_en;
      if (wr_en) begin
        ram_addr  <= {wr_bank, wr_off};
        ram_wdata <= rx_byte;
      end
      if (push) wr_bank <= ~wr_bank;
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  tenbaset_bank_tracker u_trk (
    .clk48    (clk48),
    .rst      (rst),
    .push     (push),
    .push_ent (push_ent),
    .bank_full(bank_full),
    .frm      (frm)
  );

endmodule

// File: tb/tb_tenbaset_rx_frame_ctrl.sv
// tb/tb_tenbaset_rx_frame_ctrl.sv - randomized self-checking bench for tenbaset_rx_frame_ctrl against a frame-level model
`timescale 1ns/1ps
module tb_tenbaset_rx_frame_ctrl;

  localparam int MIN_LEN = 8;
  localparam int MAX_LEN = 511;
  localparam logic [47:0] MAC = 48'h0010A47BEA80;

  logic       clk48 = 1'b0;
  logic       rst, rx_byte_valid, rx_eof, ram_we;
  logic [7:0] rx_byte, ram_wdata, drop_cnt;
  logic [9:0] ram_addr;

  tenbaset_rx_frame_ctrl_if #(.ADDR_W(9)) frm_if ();

  tenbaset_rx_frame_ctrl #(.ADDR_W(9), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk48        (clk48),
    .rst          (rst),
    .rx_byte_valid(rx_byte_valid),
    .rx_byte      (rx_byte),
    .rx_eof       (rx_eof),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .drop_cnt     (drop_cnt),
    .frm          (frm_if)
  );

  always #10 clk48 = ~clk48;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Observers: RAM image, write count, eof rise and frm_valid rise cycle numbers
  logic [7:0] ram_mem [0:1023];
  int   wr_cnt = 0, cyc = 0, eof_cyc = 0, fv_cyc = 0;
  logic eof_q = 1'b0, fv_q = 1'b0;

  always @(negedge clk48) begin
    #1;
    cyc++;
    if (ram_we === 1'b1) begin
      ram_mem[ram_addr] = ram_wdata;
      wr_cnt++;
    end
    if (rx_eof === 1'b1 && !eof_q) eof_cyc = cyc;
    eof_q = (rx_eof === 1'b1);
    if (frm_if.frm_valid === 1'b1 && !fv_q) fv_cyc = cyc;
    fv_q = (frm_if.frm_valid === 1'b1);
  end

  // Frame-level reference model
  int   m_wb, m_drop;
  bit   m_full [2];
  int   q_bank [$];
  int   q_len  [$];
  logic [7:0] exp_mem [2][512];
  logic [7:0] cur [0:1023];

  task automatic model_reset();
    m_wb = 0;
    m_drop = 0;
    m_full[0] = 0;
    m_full[1] = 0;
    q_bank.delete();
    q_len.delete();
  endtask

  function automatic int filt_cut(input int n);
`ifdef RX_MAC_FILTER_EN
    bit mok = 1, bok = 1;
    for (int i = 0; i < 6 && i < n; i++) begin
      mok = mok && (cur[i] == MAC[47-8*i -: 8]);
      bok = bok && (cur[i] == 8'hFF);
      if (!mok && !bok) return i;
    end
`endif
    return (n < 0) ? 0 : -1;
  endfunction

  task automatic do_reset();
    @(negedge clk48);
    rst = 1'b1;
    rx_byte_valid = 1'b0;
    rx_eof = 1'b0;
    frm_if.frm_ack = 1'b0;
    repeat (2) @(negedge clk48);
    rst = 1'b0;
    model_reset();
    @(negedge clk48);
  endtask

  task automatic ack_head();
    int b, l;
    bit ok = 1;
    b = q_bank.pop_front();
    l = q_len.pop_front();
    chk("frm_valid", frm_if.frm_valid, 1);
    chk("frm_bank", frm_if.frm_bank, b);
    chk("frm_len", frm_if.frm_len, l);
    for (int i = 0; i < l; i++) if (ram_mem[b*512+i] !== exp_mem[b][i]) ok = 0;
    chk("frame_data", ok, 1);
    frm_if.frm_ack = 1'b1;
    @(negedge clk48);
    frm_if.frm_ack = 1'b0;
    m_full[b] = 0;
    chk("valid_after_ack", frm_if.frm_valid, q_len.size() != 0);
    if (q_len.size() != 0) chk("next_bank_no_gap", frm_if.frm_bank, q_bank[0]);
  endtask

  // hdr: 0 random, 1 station address, 2 broadcast, 3 station address with last byte +1
  task automatic send_frame(input int n, input int hold, input bit same, input int hdr, input bit ack_commit);
    int  exp_w, cut, w0, b, l;
    bit  acc, was_empty;
    for (int i = 0; i < n; i++) cur[i] = 8'($urandom);
    if (hdr != 0) for (int i = 0; i < 6 && i < n; i++) cur[i] = (hdr == 2) ? 8'hFF : MAC[47-8*i -: 8];
    if (hdr == 3 && n >= 6) cur[5] = cur[5] + 8'd1;
    cut = filt_cut(n);
    if (m_full[m_wb]) begin
      exp_w = 0;
      acc = 0;
    end else if (cut >= 0) begin
      exp_w = cut;
      acc = 0;
    end else begin
      exp_w = (n > MAX_LEN) ? MAX_LEN : n;
      acc = (n >= MIN_LEN) && (n <= MAX_LEN);
    end
    was_empty = (q_len.size() == 0);
    if (acc) begin
      for (int i = 0; i < n; i++) exp_mem[m_wb][i] = cur[i];
      m_full[m_wb] = 1;
      q_bank.push_back(m_wb);
      q_len.push_back(n);
      m_wb ^= 1;
    end else begin
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end
    w0 = wr_cnt;
    for (int i = 0; i < n; i++) begin
      @(negedge clk48);
      rx_byte_valid = 1'b1;
      rx_byte = cur[i];
      if (i == n-1 && same) rx_eof = 1'b1;
      @(negedge clk48);
      rx_byte_valid = 1'b0;
      if (i == n-1) begin
        if (!same) rx_eof = 1'b1;
      end else begin
        repeat ($urandom_range(0, 1)) @(negedge clk48);
      end
    end
    if (ack_commit) begin
      // ack lands on the same edge as the COMMIT push
      @(negedge clk48);
      b = q_bank.pop_front();
      l = q_len.pop_front();
      chk("collide_head_bank", frm_if.frm_bank, b);
      chk("collide_head_len", frm_if.frm_len, l);
      frm_if.frm_ack = 1'b1;
      @(negedge clk48);
      frm_if.frm_ack = 1'b0;
      m_full[b] = 0;
      chk("collide_valid", frm_if.frm_valid, 1);
      chk("collide_new_bank", frm_if.frm_bank, q_bank[0]);
    end
    repeat (hold) @(negedge clk48);
    rx_eof = 1'b0;
    repeat (3) @(negedge clk48);
    chk("ram_writes", wr_cnt - w0, exp_w);
    chk("drop_cnt", drop_cnt, m_drop);
    if (acc && was_empty && !ack_commit) chk("eof_to_valid", fv_cyc - eof_cyc, 2);
  endtask

  initial begin
    rst = 1'b1;
    rx_byte_valid = 1'b0;
    rx_byte = 8'h00;
    rx_eof = 1'b0;
    frm_if.frm_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk48);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_frm_valid", frm_if.frm_valid, 0);
    chk("rst_frm_bank", frm_if.frm_bank, 0);
    chk("rst_frm_len", frm_if.frm_len, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    @(negedge clk48);

    send_frame(64, 20, 0, 1, 0);
    ack_head();

    do_reset();
    send_frame(5, 2, 0, 1, 0);
    send_frame(10, 2, 1, 1, 0);
    ack_head();

    do_reset();
    repeat (3) send_frame(20, 2, 0, 1, 0);
    ack_head();
    ack_head();

    do_reset();
    send_frame(600, 3, 0, 1, 0);
    chk("overflow_no_valid", frm_if.frm_valid, 0);
    send_frame(30, 2, 0, 1, 0);
    ack_head();

    do_reset();
    send_frame(20, 2, 0, 1, 0);
    send_frame(20, 2, 0, 1, 1);
    ack_head();

    do_reset();
    send_frame(7, 1, 1, 1, 0);
    send_frame(8, 1, 1, 1, 0);
    ack_head();
    send_frame(511, 2, 1, 1, 0);
    ack_head();
    send_frame(512, 2, 1, 1, 0);

    do_reset();
    send_frame(20, 2, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk48);
      rx_byte_valid = 1'b1;
      rx_byte = 8'($urandom);
      @(negedge clk48);
      rx_byte_valid = 1'b0;
    end
    do_reset();
    chk("midrst_frm_valid", frm_if.frm_valid, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    send_frame(12, 2, 0, 1, 0);
    ack_head();

`ifdef RX_MAC_FILTER_EN
    do_reset();
    send_frame(20, 2, 0, 3, 0);
    send_frame(20, 2, 0, 2, 0);
    ack_head();
`endif

    do_reset();
    for (int k = 0; k < 40; k++) begin
      int r, n;
      r = $urandom_range(0, 9);
      if (r == 0)      n = $urandom_range(505, 515);
      else if (r == 1) n = $urandom_range(1, 7);
      else             n = $urandom_range(8, 60);
      send_frame(n, $urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
      if (q_len.size() != 0 && $urandom_range(0, 1) == 1) begin
        ack_head();
      end else if (q_len.size() == 0 && $urandom_range(0, 3) == 0) begin
        frm_if.frm_ack = 1'b1;
        @(negedge clk48);
        frm_if.frm_ack = 1'b0;
        chk("idle_ack_ignored", frm_if.frm_valid, 0);
      end
    end
    while (q_len.size() != 0) ack_head();

    do_reset();
    repeat (260) send_frame(1, 1, 0, 0, 0);
    chk("drop_saturated", drop_cnt, 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
